// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed when the operation starts and committed after a fixed busy window.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   localparam logic [31:0] MULT_N = 32'(MULT_CYCLES);
   localparam logic [31:0] DIV_N  = 32'(DIV_CYCLES);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_we_q, pend_we_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   // op[0] selects unsigned for both MULT/MULTU and DIV/DIVU
   logic        is_unsigned;
   logic [63:0] a_ext, b_ext, prod;
   logic        a_neg, b_neg, b_zero;
   logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
   logic [31:0] div_quo, div_rem;

   always_comb begin
      is_unsigned = op[0];
      a_ext = is_unsigned ? {32'h0, a} : {{32{a[31]}}, a};
      b_ext = is_unsigned ? {32'h0, b} : {{32{b[31]}}, b};
      prod  = a_ext * b_ext;

      // Sign-magnitude divide; also yields 0x80000000 / -1 = 0x80000000 rem 0
      a_neg  = ~is_unsigned & a[31];
      b_neg  = ~is_unsigned & b[31];
      b_zero = (b == '0);
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
      b_safe = b_zero ? 32'd1 : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      div_quo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      div_rem = a_neg ? -r_mag : r_mag;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_we_d = pend_we_q;
      busy_d    = busy_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  3'd0, 3'd1: begin
                     pend_hi_d = prod[63:32];
                     pend_lo_d = prod[31:0];
                     pend_we_d = 1'b1;
                     cnt_d     = MULT_N;
                     busy_d    = 1'b1;
                     state_d   = MUL;
                  end
                  3'd2, 3'd3: begin
                     pend_hi_d = div_rem;
                     pend_lo_d = div_quo;
                     pend_we_d = ~b_zero;
                     cnt_d     = DIV_N;
                     busy_d    = 1'b1;
                     state_d   = DIV;
                  end
                  3'd4:    hi_d = a;
                  3'd5:    lo_d = a;
                  default: ;
               endcase
            end
         end
         MUL, DIV: begin
            if (cnt_q == 32'd1) begin
               if (pend_we_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_we_q <= 1'b0;
         busy_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_we_q <= pend_we_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random ops
// compared against an arithmetic model of HI/LO and the busy window.
module tb_md_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result {hi, lo} from plain integer arithmetic
   function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, p, q, r;
      logic [63:0] u;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         3'd0: begin p = sx * sy; return p; end
         3'd1: begin u = {32'h0, x} * {32'h0, y}; return u; end
         3'd2: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
         default: return {x % y, x / y};
      endcase
   endfunction

   // poke: 0 none, 1 random starts while busy, 2 alternating MULT / MTLO 0xAAAA
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int poke);
      logic [63:0] r;
      int n, exp_n;
      bit alt;
      alt = 1'b0;
      exp_n = 0;
      if (o <= 3'd1) exp_n = MC;
      else if (o <= 3'd3) exp_n = DC;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      if (exp_n == 0) begin
         if (o == 3'd4) m_hi = x;
         if (o == 3'd5) m_lo = x;
         @(negedge clk);
         chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
         chk({tag, ".hi"}, hi, m_hi);
         chk({tag, ".lo"}, lo, m_lo);
         return;
      end
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy || n > 100) break;
         n++;
         if (hi !== m_hi || lo !== m_lo) begin
            chk({tag, ".hold_hi"}, hi, m_hi);
            chk({tag, ".hold_lo"}, lo, m_lo);
         end
         if (poke == 1) begin
            start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
         end else if (poke == 2) begin
            start = 1'b1; op = alt ? 3'd5 : 3'd0; a = 32'hAAAA; b = 32'h3;
            alt = ~alt;
         end
      end
      start = 1'b0;
      if (!(o >= 3'd2 && y == '0)) begin
         r = ref_res(o, x, y);
         m_hi = r[63:32];
         m_lo = r[31:0];
      end
      chk({tag, ".cycles"}, n, exp_n);
      chk({tag, ".hi"}, hi, m_hi);
      chk({tag, ".lo"}, lo, m_lo);
      // A start landing on the commit edge must not launch a new operation
      @(negedge clk);
      chk({tag, ".idle_after"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      // Reset state, checked while reset is held
      #2;
      chk("rst.busy", {31'b0, busy}, 32'd0);
      chk("rst.hi", hi, 32'd0);
      chk("rst.lo", lo, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Preload so the hold checks see non-zero old values
      run_op("mthi0", 3'd4, 32'hCAFE0001, 32'h0, 0);
      run_op("mtlo0", 3'd5, 32'hBEEF0002, 32'h0, 0);
      run_op("mult_neg", 3'd0, 32'hFFFFFFFE, 32'h00000003, 0);
      chk("mult_neg.hi_const", hi, 32'hFFFFFFFF);
      chk("mult_neg.lo_const", lo, 32'hFFFFFFFA);
      run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      chk("multu_max.hi_const", hi, 32'hFFFFFFFE);
      chk("multu_max.lo_const", lo, 32'h00000001);
      run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'h00000002, 0);
      chk("div_neg.lo_const", lo, 32'hFFFFFFFD);
      chk("div_neg.hi_const", hi, 32'hFFFFFFFF);
      run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
      chk("div_ovf.lo_const", lo, 32'h80000000);
      chk("div_ovf.hi_const", hi, 32'h00000000);
      run_op("mthi1", 3'd4, 32'h12345678, 32'h0, 0);
      run_op("divu_zero", 3'd3, 32'd5, 32'd0, 0);
      chk("divu_zero.hi_const", hi, 32'h12345678);
      run_op("div_zero", 3'd2, 32'hDEADBEEF, 32'd0, 1);
      run_op("divu_poke", 3'd3, 32'd100, 32'd7, 2);
      chk("divu_poke.hi_const", hi, 32'd2);
      chk("divu_poke.lo_const", lo, 32'd14);
      run_op("nop6", 3'd6, 32'h11111111, 32'h2, 0);
      run_op("nop7", 3'd7, 32'h22222222, 32'h3, 0);

      // Random operations, some with starts fired while busy
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
         run_op($sformatf("rnd%0d", i), ro, ra, rb, int'($urandom_range(0, 1)));
      end

      // Reset mid-divide discards the pending result
      @(negedge clk);
      start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst.busy", {31'b0, busy}, 32'd0);
      chk("mid_rst.hi", hi, 32'd0);
      chk("mid_rst.lo", lo, 32'd0);
      #1 reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("post_rst.busy", {31'b0, busy}, 32'd0);
         chk("post_rst.hi", hi, 32'd0);
         chk("post_rst.lo", lo, 32'd0);
      end
      run_op("after_rst", 3'd1, 32'd6, 32'd7, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL timeout checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request strobe; sampled on the rising edge of clk.
REQ-006 op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 a  input  32  rs operand (dividend or multiplicand).
REQ-008 b  input  32  rt operand (divisor or multiplier).
REQ-009 busy  output  1  registered; high while a multiply or divide is in flight.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, MUL, DIV.
REQ-013 In IDLE, start=1 with op 0/1 at edge k SHALL latch the 64-bit product into pending registers, load the counter with MULT_CYCLES, and enter MUL.
REQ-014 In IDLE, start=1 with op 2/3 at edge k SHALL latch quotient and remainder into pending registers, load the counter with DIV_CYCLES, and enter DIV.
REQ-015 busy SHALL be 1 in the cycles following edges k .. k+N-1 and 0 after edge k+N, where N is the loaded count; this is N cycles high in total.
REQ-016 At edge k+N the unit SHALL copy the pending values to hi/lo, return to IDLE, and clear busy in the same edge.
REQ-017 hi/lo SHALL NOT change between edge k and edge k+N; readers see the old values while busy=1.
REQ-018 MULT SHALL compute the signed 32x32 product and MULTU the unsigned product; hi gets bits 63:32 and lo gets bits 31:0.
REQ-019 DIV SHALL use signed truncation toward zero: lo = quotient, hi = remainder with the sign of the dividend.
REQ-020 DIVU SHALL use unsigned division: lo = quotient, hi = remainder.
REQ-021 DIV with a=0x80000000 and b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-022 Divide with b=0 (DIV or DIVU) SHALL hold busy for DIV_CYCLES and then leave hi/lo unchanged.
REQ-023 In IDLE, start=1 with op 4 SHALL write hi<=a at that edge; op 5 SHALL write lo<=a at that edge. Neither raises busy.
REQ-024 start with op 6/7 SHALL have no effect.
REQ-025 start=1 while busy=1 (any op, including MTHI/MTLO) SHALL be ignored. The pipeline is responsible for stalling on (start | busy).
REQ-026 start=1 at the same edge where busy falls (edge k+N) SHALL be ignored; a new operation is accepted only at an edge where the FSM is in IDLE before the edge.
REQ-027 Operand changes on a/b after edge k SHALL NOT affect the in-flight result.

Reset
REQ-028 While reset=1, the unit SHALL drive busy=0, hi=0, lo=0, state=IDLE, counter=0, and pending registers=0, asynchronously and without waiting for a clock edge.
REQ-029 Reset asserted mid-operation SHALL discard the pending result; no commit SHALL occur after reset is released.
REQ-030 After reset is released, the first rising edge SHALL accept start normally.

Verification
REQ-031 MULT a=0xFFFFFFFE, b=0x00000003 -> busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo hold their old values during busy.
REQ-032 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 DIV a=0xFFFFFFF9, b=0x00000002 -> busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 MTHI a=0x12345678, then DIVU a=5, b=0 -> busy high for 10 cycles, then hi=0x12345678 and lo unchanged.
REQ-035 DIVU 100/7 started; during busy, MULT start and MTLO a=0xAAAA are applied -> both ignored; final hi=2, lo=14, busy high for exactly 10 cycles.
REQ-036 DIV started; reset pulsed between edges during cycle 4 -> busy=0, hi=lo=0 immediately; after release, no commit within 20 cycles.
